// File: rtl/fft_pa2se_pkg.sv
// Shared types and constants for the FFT32 parallel-to-serial converter.
// Lane count is fixed at 4, so the lane counter is 2 bits wide.
package fft_pa2se_pkg;

    localparam int NL    = 4;
    localparam int CNT_W = 2;

    localparam logic [CNT_W-1:0] CNT_FIRST = 2'd0;
    localparam logic [CNT_W-1:0] CNT_LAST  = 2'd3;

    // state   | meaning
    // S_IDLE  | shift register empty, waiting for START
    // S_SHIFT | shift register holds a vector, one lane out per clock
    typedef enum logic {
        S_IDLE  = 1'b0,
        S_SHIFT = 1'b1
    } ser_state_e;

endpackage

// File: rtl/fft_pa2se.sv
// Parallel-to-serial converter: one 4-lane complex vector in per START,
// one sample out per clock, with a one-entry pending buffer for gap-free streams.
module fft_pa2se
    import fft_pa2se_pkg::*;
#(
    parameter int NB = 16
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             START,
    input  logic [NL*NB-1:0] IR,
    input  logic [NL*NB-1:0] II,
    output logic [NB-1:0]    DR,
    output logic [NB-1:0]    DI,
    output logic             VLD,
    output logic             RDY,
    output logic             FULL,
    output logic             OVF
);

    ser_state_e         state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [NL*NB-1:0]   sr_re_q, sr_re_d, sr_im_q, sr_im_d;
    logic [NL*NB-1:0]   pb_re_q, pb_re_d, pb_im_q, pb_im_d;
    logic               pb_v_q, pb_v_d;
    logic               ovf_q, ovf_d;
    logic [NB-1:0]      dr_q, dr_d, di_q, di_d;
    logic               vld_q, vld_d, rdy_q, rdy_d;

    logic [NB-1:0]      lane_re, lane_im;
    logic               last;

    always_comb begin
        lane_re = '0;
        lane_im = '0;
        case (cnt_q)
            2'd0: begin lane_re = sr_re_q[4*NB-1:3*NB]; lane_im = sr_im_q[4*NB-1:3*NB]; end
            2'd1: begin lane_re = sr_re_q[3*NB-1:2*NB]; lane_im = sr_im_q[3*NB-1:2*NB]; end
            2'd2: begin lane_re = sr_re_q[2*NB-1:NB];   lane_im = sr_im_q[2*NB-1:NB];   end
            default: begin lane_re = sr_re_q[NB-1:0];   lane_im = sr_im_q[NB-1:0];      end
        endcase
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        sr_re_d = sr_re_q;
        sr_im_d = sr_im_q;
        pb_re_d = pb_re_q;
        pb_im_d = pb_im_q;
        pb_v_d  = pb_v_q;
        ovf_d   = ovf_q;

        vld_d = (state_q == S_SHIFT);
        rdy_d = vld_d && (cnt_q == CNT_FIRST);
        dr_d  = vld_d ? lane_re : '0;
        di_d  = vld_d ? lane_im : '0;
        last  = vld_d && (cnt_q == CNT_LAST);

        if (state_q == S_IDLE) begin
            if (START) begin
                sr_re_d = IR;
                sr_im_d = II;
                cnt_d   = CNT_FIRST;
                state_d = S_SHIFT;
            end
        end else if (!last) begin
            cnt_d = cnt_q + 2'd1;
            if (START) begin
                if (!pb_v_q) begin
                    pb_re_d = IR;
                    pb_im_d = II;
                    pb_v_d  = 1'b1;
                end else begin
                    ovf_d = 1'b1;
                end
            end
        end else begin
            cnt_d = CNT_FIRST;
            // On the last lane the pending slot drains, so a START here always fits.
            if (pb_v_q) begin
                sr_re_d = pb_re_q;
                sr_im_d = pb_im_q;
                if (START) begin
                    pb_re_d = IR;
                    pb_im_d = II;
                end else begin
                    pb_v_d = 1'b0;
                end
            end else if (START) begin
                sr_re_d = IR;
                sr_im_d = II;
            end else begin
                state_d = S_IDLE;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            sr_re_q <= '0;
            sr_im_q <= '0;
            pb_re_q <= '0;
            pb_im_q <= '0;
            pb_v_q  <= 1'b0;
            ovf_q   <= 1'b0;
            dr_q    <= '0;
            di_q    <= '0;
            vld_q   <= 1'b0;
            rdy_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            sr_re_q <= sr_re_d;
            sr_im_q <= sr_im_d;
            pb_re_q <= pb_re_d;
            pb_im_q <= pb_im_d;
            pb_v_q  <= pb_v_d;
            ovf_q   <= ovf_d;
            dr_q    <= dr_d;
            di_q    <= di_d;
            vld_q   <= vld_d;
            rdy_q   <= rdy_d;
        end
    end

    assign DR   = dr_q;
    assign DI   = di_q;
    assign VLD  = vld_q;
    assign RDY  = rdy_q;
    assign FULL = pb_v_q;
    assign OVF  = ovf_q;

endmodule

// File: doc/fft_pa2se.md
Name: fft_pa2se

Overview:
- Parallel-to-serial converter for the FFT32 datapath. It is the transmit-side counterpart of the 4-lane serial-to-parallel deserializer.
- Accepts one 4-sample complex vector per START pulse. Emits the samples one per clock on DR/DI, lane 0 (MSB slice) first.
- A one-entry pending buffer lets upstream deliver the next vector while the current one is still shifting out. This keeps the output stream gap-free for back-to-back vectors.
- Sits between the radix-4 butterfly output and the serial output port / next serial stage.

Parameters:
- NB, 16, width of each real/imag component (matches shared `nb`).
- NL, 4, lanes per vector. Fixed at 4; counter width is 2. Other values are unsupported.

Ports:
- CLK  input  1  clock, rising edge.
- RST  input  1  synchronous reset, active-high.
- START  input  1  single-cycle strobe; IR/II hold a valid vector this cycle.
- IR  input  NB*4  real parts. Lane 0 = IR[4NB-1:3NB], lane 3 = IR[NB-1:0].
- II  input  NB*4  imag parts, same lane packing as IR.
- DR  output  NB  serial real sample.
- DI  output  NB  serial imag sample.
- VLD  output  1  DR/DI carry a valid sample this cycle.
- RDY  output  1  high on the cycle lane 0 of each frame is on DR/DI.
- FULL  output  1  pending buffer occupied.
- OVF  output  1  sticky: a vector was dropped.

Behaviour:
- Clocking and reset:
  - One clock domain. Reset is synchronous, active-high, port RST; it is sampled only on the CLK rising edge.
  - All outputs are registered.
  - On RST: DR=0, DI=0, VLD=0, RDY=0, FULL=0, OVF=0, lane counter=0, shift register invalid, pending invalid. RST has priority over START.
  - Reset mid-frame aborts the frame; remaining lanes and the pending vector are discarded.
- State:
  - Shift register SR holds the active vector, with a valid flag.
  - Pending register PB holds the next vector, with a valid flag.
  - 2-bit lane counter CNT.
- Load rules, evaluated each edge, not in reset. LAST = SR valid and CNT==3.
  - Idle (SR invalid): START loads IR/II into SR; CNT=0.
  - Busy, not LAST: START with PB empty writes PB and sets FULL=1. START with PB full drops the vector, sets OVF=1, and leaves PB unchanged.
  - LAST with PB full: PB moves to SR and CNT=0. A simultaneous START writes PB, so FULL stays 1. This case is accepted, not an overflow.
  - LAST with PB empty and START: IR/II load directly into SR (continuous stream).
  - LAST with PB empty and no START: SR becomes invalid; idle from the next cycle.
- Output timing:
  - The cycle after an edge with SR valid: VLD=1, and DR/DI = lane CNT of SR.
  - RDY=1 exactly when CNT==0 is being output.
  - CNT increments by 1 per cycle and wraps 3→0.
- Latency: START sampled at edge k (idle) → lane 0 on DR/DI with RDY=1 from edge k+1; lane 3 from edge k+4.
- Throughput: START every 4 cycles gives 100% VLD with no bubbles.
- VLD=0 forces DR=0 and DI=0. RDY is never 1 while VLD=0.
- No arithmetic; data passes bit-exact.
- OVF clears only on RST.

Decomposition:
- Shared include/parameter.vh (`FFTsfpw`) supplies nb. Lane-slice index macros (LANE_HI/LANE_LO) are added there for reuse by both converters.
- No sub-module. A single always block, or a split into pending-buffer and serializer processes, is sufficient (~150 RTL lines).

Test Plan:
- Reset then single vector: START with IR lanes {0x0001,0x0002,0x0003,0x0004}, II {0x0011,0x0012,0x0013,0x0014} → next 4 cycles DR=1,2,3,4 and DI=0x11..0x14. VLD=1 for exactly 4 cycles; RDY=1 on the first only; then VLD=0 and DR=DI=0.
- Back-to-back: START every 4th cycle for 3 vectors (lane values 0x10n+lane) → 12 consecutive VLD cycles. RDY at cycles 1, 5 and 9; FULL never set.
- Early START: second START 1 cycle after the first → FULL=1 until the first frame's lane 3. The second frame follows with no gap; FULL returns to 0 as it loads.
- Overflow: START at cycles 0, 1 and 2 → third vector dropped and OVF=1. Output shows only vectors 1 and 2 (8 samples).
- START on LAST with PB full: STARTs at cycles 0, 1 and 4 (cycle 4 = lane 3 of frame 1) → all three frames are output back-to-back, and OVF stays 0.
- Reset mid-frame: RST asserted during lane 1 with PB full → next cycle all outputs 0, FULL=0. A subsequent START restarts cleanly from lane 0.
